// File: rtl/mvma_pkg.sv
// Shared types for the matrix-vector output stage.
// Element type, bank states and the default vector length.
package mvma_pkg;

  localparam int K_DEF = 4;

  typedef logic signed [7:0] elem_t;

  localparam elem_t ELEM_MAX = 8'sh7F;
  localparam elem_t ELEM_MIN = 8'sh80;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/mvma_narrow.sv
// Narrows one 16-bit accumulator result to a signed byte.
// Optional ReLU clamp on the result with macro MVMA_OUT_RELU_EN.
module mvma_narrow
  import mvma_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic signed [15:0] data_in,
  input  logic               ovf_in,
  output elem_t              data_out
);

  localparam logic signed [16:0] RND =
    17'((1 << SHIFT) >> 1);

  logic signed [16:0] sum;
  logic signed [16:0] shifted;
  elem_t              sat;

  // round, shift, saturate; overflow forces the sign-flipped rail
  always_comb begin
    sum     = $signed({data_in[15], data_in}) + RND;
    shifted = sum >>> SHIFT;
    if (ovf_in) begin
      sat = data_in[15] ? ELEM_MAX : ELEM_MIN;
    end else if (shifted > 17'sd127) begin
      sat = ELEM_MAX;
    end else if (shifted < -17'sd128) begin
      sat = ELEM_MIN;
    end else begin
      sat = shifted[7:0];
    end
`ifdef MVMA_OUT_RELU_EN
    data_out = sat[7] ? '0 : sat;
`else
    data_out = sat;
`endif
  end

endmodule

// File: rtl/mvma_out_stage.sv
// Ping-pong output buffer: narrows results, emits K-element vectors.
// Build option MVMA_OUT_RELU_EN clamps negative outputs to zero.
module mvma_out_stage
  import mvma_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] data_in,
  input  logic               ovf_in,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [7:0]  data_out,
  output logic               m_last,
  output logic [7:0]         ovf_count
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  bank_state_t   state [2];
  logic          fill_sel;
  logic          drain_sel;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  elem_t         mem [2][K];
  elem_t         narrowed;
  logic          accept;
  logic          take;

  mvma_narrow #(
    .SHIFT(SHIFT)
  ) u_narrow (
    .data_in  (data_in),
    .ovf_in   (ovf_in),
    .data_out (narrowed)
  );

  // fill bank is the only one that can be EMPTY/FILLING
  assign s_ready = (state[fill_sel] == BANK_EMPTY)
                || (state[fill_sel] == BANK_FILLING);
  assign m_valid = (state[drain_sel] == BANK_FULL)
                || (state[drain_sel] == BANK_DRAINING);

  assign accept   = s_valid && s_ready;
  assign take     = m_valid && m_ready;
  assign data_out = m_valid ? mem[drain_sel][rd_idx] : '0;
  assign m_last   = m_valid && (rd_idx == LAST);

  // bank states, indices and overflow counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state[0]  <= BANK_EMPTY;
      state[1]  <= BANK_EMPTY;
      fill_sel  <= 1'b0;
      drain_sel <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      ovf_count <= '0;
    end else begin
      if (accept) begin
        if (wr_idx == LAST) begin
          state[fill_sel] <= BANK_FULL;
          wr_idx          <= '0;
          fill_sel        <= ~fill_sel;
        end else begin
          state[fill_sel] <= BANK_FILLING;
          wr_idx          <= wr_idx + 1'b1;
        end
        if (ovf_in && (ovf_count != 8'hFF)) begin
          ovf_count <= ovf_count + 1'b1;
        end
      end
      if (take && (rd_idx == LAST)) begin
        state[drain_sel] <= BANK_EMPTY;
        rd_idx           <= '0;
        drain_sel        <= ~drain_sel;
      end else if (take) begin
        state[drain_sel] <= BANK_DRAINING;
        rd_idx           <= rd_idx + 1'b1;
      end else if (state[drain_sel] == BANK_FULL) begin
        state[drain_sel] <= BANK_DRAINING;
      end
    end
  end

  // element storage, written only into the fill bank
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[fill_sel][wr_idx] <= narrowed;
    end
  end

endmodule

// File: tb/tb_mvma_out_stage.sv
// Directed and randomized checks of mvma_out_stage.
// Second instance with SHIFT=2 shares the stimulus.
module tb_mvma_out_stage;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic signed [15:0] data_in;
  logic               ovf_in;
  logic               m_ready;
  logic               s_ready, s_ready2;
  logic               m_valid, m_valid2;
  logic signed [7:0]  data_out, data_out2;
  logic               m_last, m_last2;
  logic [7:0]         ovf_count, ovf_count2;

  int total = 0;
  int bad   = 0;

  mvma_out_stage #(.K(4), .SHIFT(0)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .data_in(data_in), .ovf_in(ovf_in),
    .m_valid(m_valid), .m_ready(m_ready),
    .data_out(data_out), .m_last(m_last),
    .ovf_count(ovf_count)
  );

  mvma_out_stage #(.K(4), .SHIFT(2)) dut2 (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready2),
    .data_in(data_in), .ovf_in(ovf_in),
    .m_valid(m_valid2), .m_ready(m_ready),
    .data_out(data_out2), .m_last(m_last2),
    .ovf_count(ovf_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic o);
    int n = 0;
    s_valid = 1'b1;
    data_in = d;
    ovf_in  = o;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
    data_in = 'x;
    ovf_in  = 'x;
  endtask

  task automatic recv(input string tag, input int e1,
                      input int e2, input logic last);
    int n = 0;
    m_ready = 1'b1;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_data"}, data_out, e1);
    chk({tag, "_data_s2"}, data_out2, e2);
    chk({tag, "_last"}, m_last, last);
    tick();
    m_ready = 1'b0;
  endtask

  function automatic int model(input logic [15:0] d,
                               input logic o, input int sh);
    int v;
    int dv;
    if (o) return d[15] ? 127 : -128;
    v  = int'($signed(d));
    dv = 1 << sh;
    if (sh > 0) v = v + dv / 2;
    v = (v >= 0) ? v / dv : -((-v + dv - 1) / dv);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  initial begin
    int sent;
    int acc_n;
    int hs_n;
    int in_n;
    int out_n;
    int cyc;
    int ovf_m;
    int tmp;
    int q[$];
    logic acc;
    logic hs;
    logic stall;
    logic [15:0] cur_d;
    logic cur_o;
    logic signed [7:0] held;

    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = '0;
    ovf_in  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_last", m_last, 0);
    chk("rst_ovf", ovf_count, 0);

    // clamp vector
    send(16'd5, 1'b0);
    send(-16'sd3, 1'b0);
    send(16'd300, 1'b0);
    chk("early_m_valid", m_valid, 0);
    send(-16'sd200, 1'b0);
    recv("v0e0", 5, 1, 1'b0);
    recv("v0e1", -3, -1, 1'b0);
    recv("v0e2", 127, 75, 1'b0);
    recv("v0e3", -128, -50, 1'b1);
    chk("idle_m_valid", m_valid, 0);
    chk("idle_data", data_out, 0);
    chk("idle_last", m_last, 0);

    // rounding vector
    send(16'd6, 1'b0);
    send(-16'sd6, 1'b0);
    send(16'd0, 1'b0);
    send(16'd1, 1'b0);
    recv("v1e0", 6, 2, 1'b0);
    recv("v1e1", -6, -1, 1'b0);
    recv("v1e2", 0, 0, 1'b0);
    recv("v1e3", 1, 0, 1'b1);

    // overflow vector
    send(16'h8001, 1'b1);
    send(16'h7FFF, 1'b1);
    send(16'd0, 1'b0);
    send(16'h0080, 1'b0);
    chk("ovf_count2", ovf_count, 2);
    recv("v2e0", 127, 127, 1'b0);
    recv("v2e1", -128, -128, 1'b0);
    recv("v2e2", 0, 0, 1'b0);
    recv("v2e3", 127, 32, 1'b1);

    // backpressure: 12 offered, 8 accepted
    m_ready = 1'b0;
    s_valid = 1'b1;
    ovf_in  = 1'b0;
    sent    = 0;
    data_in = 16'd10;
    for (int c = 0; c < 20; c++) begin
      acc = s_valid && s_ready;
      tick();
      if (acc) sent++;
      if (sent == 12) s_valid = 1'b0;
      data_in = 16'(10 + sent);
    end
    chk("bp_accepted", sent, 8);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m_valid", m_valid, 1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_valid", m_valid, 1);
      chk("bp_data", data_out, 10 + i);
      chk("bp_last", m_last, (i % 4) == 3);
      tick();
      if (i == 2) chk("bp_s_ready_lo", s_ready, 0);
      if (i == 3) chk("bp_s_ready_hi", s_ready, 1);
    end
    m_ready = 1'b0;
    chk("bp_done", m_valid, 0);

    // random traffic against the model
    in_n  = 0;
    out_n = 0;
    cyc   = 0;
    ovf_m = 2;
    stall = 1'b0;
    held  = '0;
    while (out_n < 160 && cyc < 5000) begin
      tmp = ($urandom_range(0, 3) == 0) ? int'($urandom)
          : int'($urandom_range(0, 600)) - 300;
      cur_d   = tmp[15:0];
      cur_o   = ($urandom_range(0, 7) == 0);
      s_valid = (in_n < 160) && ($urandom_range(0, 1) == 1);
      data_in = cur_d;
      ovf_in  = cur_o;
      m_ready = ($urandom_range(0, 2) != 0);
      if (stall) begin
        chk("rnd_hold_valid", m_valid, 1);
        chk("rnd_hold_data", data_out, held);
      end
      if (m_valid) begin
        if (q.size() == 0) begin
          chk("rnd_extra", 1, 0);
        end else begin
          chk("rnd_data", data_out, q[0]);
          chk("rnd_last", m_last, (out_n % 4) == 3);
        end
      end
      acc   = s_valid && s_ready;
      hs    = m_valid && m_ready;
      stall = m_valid && !m_ready;
      held  = data_out;
      tick();
      cyc++;
      if (acc) begin
        q.push_back(model(cur_d, cur_o, 0));
        in_n++;
        if (cur_o && ovf_m < 255) ovf_m++;
      end
      if (hs && q.size() > 0) begin
        void'(q.pop_front());
        out_n++;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("rnd_out_count", out_n, 160);
    chk("rnd_queue_empty", q.size(), 0);
    chk("rnd_ovf_count", ovf_count, ovf_m);

    // full-rate streaming and counter saturation
    s_valid = 1'b1;
    ovf_in  = 1'b1;
    data_in = 16'h8000;
    m_ready = 1'b1;
    acc_n   = 0;
    hs_n    = 0;
    for (int c = 0; c < 300; c++) begin
      acc = s_valid && s_ready;
      hs  = m_valid && m_ready;
      if (c == 150) chk("stream_data", data_out, 127);
      tick();
      if (acc) acc_n++;
      if (hs) hs_n++;
    end
    s_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      hs = m_valid && m_ready;
      tick();
      if (hs) hs_n++;
    end
    m_ready = 1'b0;
    chk("stream_in", acc_n, 300);
    chk("stream_out", hs_n, 300);
    chk("ovf_saturate", ovf_count, 255);

    // reset with a partial vector in flight
    send(16'd50, 1'b0);
    send(16'd51, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_s_ready", s_ready, 1);
    chk("mid_m_valid", m_valid, 0);
    chk("mid_ovf", ovf_count, 0);
    m_ready = 1'b1;
    repeat (3) tick();
    chk("mid_no_out", m_valid, 0);
    m_ready = 1'b0;
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    send(16'd3, 1'b0);
    send(16'd4, 1'b0);
    recv("v3e0", 1, 0, 1'b0);
    recv("v3e1", 2, 1, 1'b0);
    recv("v3e2", 3, 1, 1'b0);
    recv("v3e3", 4, 1, 1'b1);
    chk("end_idle", m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
